// File: rtl/tx_scheduler_pkg.sv
// Shared types and helpers for the tx_scheduler slice.
// The tag byte format is used only when TX_SCHED_TAG_EN is defined.
package tx_scheduler_pkg;

    localparam int IDX_W = 3;
    localparam int TAG_W = 8;
    localparam logic [3:0] TAG_PREFIX = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEND,
        ST_GAP,
        ST_WAIT
    } state_t;

    function automatic logic [IDX_W-1:0] rr_next(logic [IDX_W-1:0] idx, int nreq);
        return (int'(idx) + 1 >= nreq) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [TAG_W-1:0] tag_byte(logic [IDX_W-1:0] idx);
        return {TAG_PREFIX, 1'b0, idx};
    endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// Producer/send-controller bus of the tx_scheduler.
// master = producers + send controller side, slave = scheduler.
interface tx_scheduler_if #(parameter int NREQ = 2);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][7:0]   req_byte;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ack;
    logic [NREQ-1:0]        grant;
    logic                   transmit;
    logic [7:0]             tx_byte;
    logic                   is_transmitting;
    logic                   pkt_abort;

    modport master (
        output req_valid, req_byte, req_last, is_transmitting,
        input  req_ack, grant, transmit, tx_byte, pkt_abort
    );

    modport slave (
        input  req_valid, req_byte, req_last, is_transmitting,
        output req_ack, grant, transmit, tx_byte, pkt_abort
    );

endinterface

// File: rtl/tx_scheduler_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// wrapping modulo NREQ. Returns one-hot pick, its index and an any flag.
module tx_scheduler_rr_picker
    import tx_scheduler_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req_valid[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
                    pick[i] = 1'b1;
                    idx     = IDX_W'(i);
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Per-packet round-robin scheduler in front of the single serial send controller.
// Define TX_SCHED_TAG_EN to prefix every packet with tag byte 0xA0|idx.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int MAXPKT = 64
) (
    input  logic          clk,
    input  logic          n_reset,
    tx_scheduler_if.slave bus
);

    localparam logic [7:0] MAX_CNT = 8'(MAXPKT);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       txb_q, txb_d;
    logic             last_q, last_d;
    logic             tx_q, tx_d;
    logic             abort_q, abort_d;

    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             cur_valid, cur_last;
    logic [7:0]       cur_byte;

    tx_scheduler_rr_picker #(.NREQ(NREQ)) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_q),
        .pick      (pick),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    // Only the packet owner's lane is ever looked at while a grant is held.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_byte  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                cur_valid = bus.req_valid[i];
                cur_last  = bus.req_last[i];
                cur_byte  = bus.req_byte[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        txb_d   = txb_q;
        tx_d    = 1'b0;
        ack_d   = '0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    last_d  = 1'b0;
`ifdef TX_SCHED_TAG_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_SEND;
`endif
                end
            end
`ifdef TX_SCHED_TAG_EN
            ST_HDR: begin
                if (!bus.is_transmitting) begin
                    tx_d    = 1'b1;
                    txb_d   = tag_byte(gidx_q);
                    state_d = ST_GAP;
                end
            end
`endif
            ST_SEND: begin
                if (!bus.is_transmitting && cur_valid) begin
                    tx_d    = 1'b1;
                    txb_d   = cur_byte;
                    ack_d   = grant_q;
                    cnt_d   = cnt_q + 8'd1;
                    last_d  = cur_last;
                    state_d = ST_GAP;
                end
            end
            // Controller raises busy only the cycle after transmit.
            ST_GAP: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.is_transmitting) begin
                    if (last_q || cnt_q == MAX_CNT) begin
                        grant_d = '0;
                        rr_d    = rr_next(gidx_q, NREQ);
                        cnt_d   = '0;
                        abort_d = !last_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            txb_q   <= '0;
            tx_q    <= 1'b0;
            ack_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            txb_q   <= txb_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.req_ack   = ack_q;
    assign bus.transmit  = tx_q;
    assign bus.tx_byte   = txb_q;
    assign bus.pkt_abort = abort_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler (NREQ=2, MAXPKT=4); expectations follow
// TX_SCHED_TAG_EN so the same bench covers both builds.
module tb_tx_scheduler;

    localparam int NREQ = 2;
    localparam int BUSY = 5;
`ifdef TX_SCHED_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic clk;
    logic n_reset;
    tx_scheduler_if #(.NREQ(NREQ)) bus ();

    tx_scheduler #(.NREQ(NREQ), .MAXPKT(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Producers: byte lists per requester, advanced on req_ack.
    logic [7:0] pbyte [NREQ][64];
    bit         plast [NREQ][64];
    int         plen  [NREQ];
    int         ppos  [NREQ];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NREQ; i++) ppos[i] <= 0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ack[i]) ppos[i] <= ppos[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = ppos[i] < plen[i];
            bus.req_byte[i]  = pbyte[i][ppos[i] & 63];
            bus.req_last[i]  = plast[i][ppos[i] & 63];
        end
    end

    // Send controller: busy from the cycle after transmit; unaffected by n_reset.
    int busy_cnt = 0;
    always_ff @(posedge clk) begin
        if (bus.transmit) busy_cnt <= BUSY;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.is_transmitting = (busy_cnt != 0);

    // Monitor
    int log_b [256];
    int log_o [256];
    int n_tx = 0;
    int ack_cnt [NREQ];
    int n_abort = 0;
    int cyc = 0;
    int last_cyc = 0;
    int min_gap = 1000;

    function automatic int oh2idx(logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    always_ff @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.transmit && n_tx < 256) begin
            log_b[n_tx] <= int'(bus.tx_byte);
            log_o[n_tx] <= oh2idx(bus.grant);
            n_tx        <= n_tx + 1;
            last_cyc    <= cyc;
            if (n_tx > 0 && cyc - last_cyc < min_gap) min_gap <= cyc - last_cyc;
        end
        for (int i = 0; i < NREQ; i++)
            if (bus.req_ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        if (bus.pkt_abort) n_abort <= n_abort + 1;
    end

    // Expected stream
    int ex_b [64];
    int ex_o [64];
    int n_ex;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(int i, logic [7:0] b, bit last);
        pbyte[i][plen[i]] = b;
        plast[i][plen[i]] = last;
        plen[i]++;
    endtask

    task automatic ex_pkt(int own);
        if (TAG) begin
            ex_b[n_ex] = 'hA0 | own;
            ex_o[n_ex] = own;
            n_ex++;
        end
    endtask

    task automatic ex_dat(int b, int own);
        ex_b[n_ex] = b;
        ex_o[n_ex] = own;
        n_ex++;
    endtask

    task automatic cmp_stream(string tag, int base);
        chk({tag, "_ntx"}, n_tx - base, n_ex);
        for (int k = 0; k < n_ex && base + k < 256; k++) begin
            chk($sformatf("%s_byte%0d", tag, k), log_b[base + k], ex_b[k]);
            chk($sformatf("%s_own%0d", tag, k), log_o[base + k], ex_o[k]);
        end
    endtask

    task automatic wait_done(string tag, int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (ppos[0] == plen[0] && ppos[1] == plen[1] &&
                bus.grant == '0 && !bus.is_transmitting) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, int'(ok), 1);
        tick();
        tick();
    endtask

    task automatic chk_outputs_zero(string tag);
        chk({tag, "_grant"}, int'(bus.grant), 0);
        chk({tag, "_transmit"}, int'(bus.transmit), 0);
        chk({tag, "_tx_byte"}, int'(bus.tx_byte), 0);
        chk({tag, "_req_ack"}, int'(bus.req_ack), 0);
        chk({tag, "_pkt_abort"}, int'(bus.pkt_abort), 0);
    endtask

    initial begin
        int base, a0, a1, ab, snap;
        bit found;
        n_reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            plen[i] = 0;
            ack_cnt[i] = 0;
        end
        repeat (3) tick();
        chk_outputs_zero("rst");
        n_reset = 1'b1;
        tick();

        // t1: single 3-byte packet from requester 0, latency checks.
        base = n_tx; a0 = ack_cnt[0]; n_ex = 0;
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        tick();
        chk("t1_grant_lat", int'(bus.grant), 1);
        tick();
        chk("t1_tx_lat", int'(bus.transmit), 1);
        chk("t1_first_byte", int'(bus.tx_byte), TAG ? 'hA0 : 'h11);
        chk("t1_ack_with_tx", int'(bus.req_ack), TAG ? 0 : 1);
        wait_done("t1", 300);
        ex_pkt(0); ex_dat('h11, 0); ex_dat('h22, 0); ex_dat('h33, 0);
        cmp_stream("t1", base);
        chk("t1_acks", ack_cnt[0] - a0, 3);
        chk("t1_grant_end", int'(bus.grant), 0);

        // t2: requester 1 never ends its packet inside MAXPKT=4 -> forced end.
        base = n_tx; ab = n_abort; n_ex = 0;
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 0); push(1, 8'h44, 0);
        push(1, 8'h45, 1);
        push(0, 8'h0A, 1);
        wait_done("t2", 600);
        ex_pkt(1); ex_dat('h41, 1); ex_dat('h42, 1); ex_dat('h43, 1); ex_dat('h44, 1);
        ex_pkt(0); ex_dat('h0A, 0);
        ex_pkt(1); ex_dat('h45, 1);
        cmp_stream("t2", base);
        chk("t2_abort", n_abort - ab, 1);

        // t3: both requesters continuously valid, 2-byte packets alternate.
        base = n_tx; n_ex = 0;
        push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h03, 0); push(0, 8'h04, 1);
        push(1, 8'h81, 0); push(1, 8'h82, 1); push(1, 8'h83, 0); push(1, 8'h84, 1);
        wait_done("t3", 600);
        ex_pkt(0); ex_dat('h01, 0); ex_dat('h02, 0);
        ex_pkt(1); ex_dat('h81, 1); ex_dat('h82, 1);
        ex_pkt(0); ex_dat('h03, 0); ex_dat('h04, 0);
        ex_pkt(1); ex_dat('h83, 1); ex_dat('h84, 1);
        cmp_stream("t3", base);

        // t4: owner stalls 10 cycles mid-packet while requester 1 waits.
        base = n_tx; a0 = ack_cnt[0]; n_ex = 0;
        push(0, 8'h51, 0);
        push(1, 8'h91, 1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (ack_cnt[0] != a0) found = 1'b1;
        end
        chk("t4_first_ack", int'(found), 1);
        snap = n_tx;
        repeat (10) tick();
        chk("t4_no_tx_in_stall", n_tx - snap, 0);
        chk("t4_grant_held", int'(bus.grant), 1);
        push(0, 8'h52, 0); push(0, 8'h53, 1);
        wait_done("t4", 400);
        ex_pkt(0); ex_dat('h51, 0); ex_dat('h52, 0); ex_dat('h53, 0);
        ex_pkt(1); ex_dat('h91, 1);
        cmp_stream("t4", base);

        // t5: reset while in WAIT, then requester 1 alone.
        push(0, 8'h61, 0); push(0, 8'h62, 1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (bus.transmit && bus.tx_byte == 8'h61) found = 1'b1;
        end
        chk("t5_saw_byte", int'(found), 1);
        tick();
        #2;
        n_reset = 1'b0;
        plen[0] = 0;
        plen[1] = 0;
        #1;
        chk_outputs_zero("t5_rst");
        tick();
        n_reset = 1'b1;
        repeat (8) tick();
        base = n_tx; a1 = ack_cnt[1]; n_ex = 0;
        push(1, 8'h71, 1);
        tick();
        chk("t5_grant_r1", int'(bus.grant), 2);
        wait_done("t5", 200);
        ex_pkt(1); ex_dat('h71, 1);
        cmp_stream("t5", base);
        chk("t5_acks", ack_cnt[1] - a1, 1);

        // t6: single-byte packet.
        base = n_tx; a0 = ack_cnt[0]; n_ex = 0;
        push(0, 8'h5A, 1);
        wait_done("t6", 200);
        ex_pkt(0); ex_dat('h5A, 0);
        cmp_stream("t6", base);
        chk("t6_acks", ack_cnt[0] - a0, 1);

        chk("min_tx_spacing_ok", int'(min_gap >= 3), 1);
        chk("abort_total", n_abort, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Byte-level scheduler that shares the single serial send controller between up to NREQ byte producers (performance random-data stream, debug sample/counter dump, health/status reporter). Sits between the sample-to-transmit logic and the send controller. Grants the link per packet, never interleaves bytes of two packets, rotates priority round-robin and polices packet length.

## Interface
- NREQ, 2: number of requesters (2..8).
- MAXPKT, 64: maximum bytes per packet before forced termination (1..255).
- clk  in  1  system clock (125 MHz domain).
- n_reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a byte on req_byte[8i+7:8i].
- req_byte  in  8*NREQ  packed request bytes.
- req_last  in  NREQ  byte presented by requester i ends its packet.
- req_ack  out  NREQ  one-cycle pulse: byte of requester i consumed.
- grant  out  NREQ  one-hot, current packet owner; 0 when idle.
- transmit  out  1  one-cycle start pulse to send controller.
- tx_byte  out  8  byte to send; held stable from transmit until next transmit.
- is_transmitting  in  1  send controller busy.
- pkt_abort  out  1  one-cycle pulse when MAXPKT forced a packet end.

## Operation
- States: IDLE, HDR, SEND, GAP, WAIT.
- IDLE: if any req_valid, pick first valid index at or after rr_ptr (wrapping modulo NREQ); register grant; go HDR (macro on) or SEND.
- HDR: when is_transmitting=0: transmit=1, tx_byte={4'hA, 1'b0, idx[2:0]}; go GAP. No req_ack.
- SEND: when is_transmitting=0 and req_valid[g]=1: transmit=1, tx_byte=req_byte[g], req_ack[g]=1, byte_cnt+1; go GAP. If req_valid[g]=0, stay (packet owner keeps link; no other requester served).
- GAP: one cycle, is_transmitting ignored (send controller raises busy the cycle after transmit); go WAIT.
- WAIT: when is_transmitting=0: if last byte sent had req_last=1 or byte_cnt=MAXPKT, release: grant=0, rr_ptr=(g+1) mod NREQ, byte_cnt=0, go IDLE; else SEND.
- Forced end at byte_cnt=MAXPKT without req_last: pkt_abort pulses on release cycle; requester's remaining bytes start a new packet under normal arbitration.
- byte_cnt: 8 bits, counts data bytes only (header excluded), saturation impossible since MAXPKT≤255.
- req_valid deasserted mid-packet by a requester other than the owner: no effect.
- Reset (any time, incl. mid-byte): state IDLE, grant=0, rr_ptr=0, byte_cnt=0, transmit=0, tx_byte=0, req_ack=0, pkt_abort=0. A byte already started in the send controller is not recalled.

## Timing
- All outputs registered.
- Request seen in IDLE at cycle t -> grant at t+1; first transmit at t+2 earliest (header or data).
- req_ack coincides with transmit; producer presents next byte (or drops req_valid) from the following cycle.
- Minimum spacing between transmit pulses: 3 cycles (transmit, GAP, WAIT with is_transmitting already low).
- Release and new grant cannot share a cycle: ≥1 IDLE cycle between packets.

## Configuration
- TX_SCHED_TAG_EN defined: HDR state active; every packet preceded by tag byte 0xA0|idx.
- Not defined: HDR state removed; IDLE goes directly to SEND; output stream carries data bytes only (performance mode, host must know single source).

## Structure
- Shared package: state enum, tag prefix constant 4'hA, tag byte width, helper for round-robin next-index.
- One natural sub-module: rr_picker (combinational priority rotate: req_valid, rr_ptr -> one-hot pick, index, any).

## Test plan
- Single requester 0, 3-byte packet 0x11,0x22,0x33(last), send busy 5 cycles/byte -> tx_byte 0xA0,0x11,0x22,0x33 (tag on); req_ack three pulses; grant returns to 0.
- Both requesters valid continuously, 2-byte packets -> packet order 0,1,0,1; no byte of req1 between req0's two bytes.
- Requester 1 never asserts req_last, MAXPKT=4 -> exactly 4 data bytes, pkt_abort pulse, requester 0 (valid) served next.
- Owner drops req_valid for 10 cycles mid-packet while requester 1 valid -> no transmit during gap; owner resumes, packet completes, then requester 1 granted.
- n_reset asserted in WAIT -> all outputs 0 next edge-independent; after release, requester 1 alone valid -> grant=2'b10 one cycle after request.
- Macro off, requester 0 sends 0x5A(last) -> single transmit with 0x5A, no 0xA0 byte.
